// File: rtl/mem_stage_pkg.sv
// Shared definitions for the buffered memory stage: default parameters,
// FSM state encoding and the byte-to-word address helper.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEST_W = 4;
  localparam int DEF_DEPTH  = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD      = 2'd2;
  localparam logic [1:0] RD_DONE = 2'd3;

  // Byte address to word address; callers truncate to their own ADDR_W.
  function automatic logic [63:0] word_addr(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_wbuf.sv
// Circular write buffer of {word address, data} entries for mem_stage_wbuf.
// With WBUF_FWD_EN defined it also exposes a youngest-match address lookup.
module mem_wbuf
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
`ifdef WBUF_FWD_EN
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        hit_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;

  // Storage carries no reset; validity is tracked purely by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

`ifdef WBUF_FWD_EN
  // Slot gi is the entry gi places behind the head, so higher gi is younger.
  logic [DEPTH-1:0]  match;
  logic [DATA_W-1:0] cand [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] idx;
    assign idx       = rd_ptr_reg + PTR_W'(gi);
    assign match[gi] = (count_reg > (PTR_W+1)'(gi)) && (addr_mem[idx] == lookup_addr);
    assign cand[gi]  = data_mem[idx];
  end

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit      = 1'b1;
        hit_data = cand[k];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_stage_wbuf.sv
// Memory pipeline stage with a posted write buffer and a req/ack backing port.
// Optional macro WBUF_FWD_EN adds store-to-load forwarding from the buffer.
module mem_stage_wbuf
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WB_EN,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [DATA_W-1:0]      ALU_Res,
  input  logic [DATA_W-1:0]      Val_Rm,
  input  logic [DEST_W-1:0]      Dest,
  input  logic [31:0]            pc,
  output logic                   WB_EN_out,
  output logic                   MEM_R_EN_out,
  output logic [DATA_W-1:0]      ALU_Res_out,
  output logic [DATA_W-1:0]      DataMemory_out,
  output logic [DEST_W-1:0]      MEM_Dest,
  output logic [31:0]            pc_out,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] wbuf_count,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr;
  logic              is_load;
  logic              is_store;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              fwd_hit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] load_data_reg;

  assign addr     = ADDR_W'(word_addr(64'(ALU_Res)));
  // A load wins when both enables are set; the store half is dropped.
  assign is_load  = MEM_R_EN;
  assign is_store = MEM_W_EN & ~MEM_R_EN;
  assign push     = is_store & ~full;
  assign pop      = (state_reg == WR) & mem_ack;

  assign MEM_R_EN_out = MEM_R_EN;
  assign ALU_Res_out  = ALU_Res;
  assign MEM_Dest     = Dest;
  assign pc_out       = pc;
  assign WB_EN_out    = WB_EN & ready;

`ifdef WBUF_FWD_EN
  logic              lookup_hit;
  logic [DATA_W-1:0] fwd_data;

  mem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (addr),
    .push_data   (Val_Rm),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .lookup_addr (addr),
    .hit         (lookup_hit),
    .hit_data    (fwd_data),
    .count       (wbuf_count)
  );

  assign fwd_hit        = is_load & lookup_hit;
  assign DataMemory_out = fwd_hit ? fwd_data : load_data_reg;
`else
  mem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (addr),
    .push_data (Val_Rm),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (wbuf_count)
  );

  assign fwd_hit        = 1'b0;
  assign DataMemory_out = load_data_reg;
`endif

  // A load only releases the pipeline from RD_DONE or on a buffer hit.
  always_comb begin
    ready = 1'b1;
    if (is_load)
      ready = fwd_hit | (state_reg == RD_DONE);
    else if (is_store)
      ready = ~full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      load_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Reads wait for an empty buffer so earlier stores land first.
          if (is_load && !fwd_hit && empty) begin
            state_reg <= RD;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= addr;
          end else if (!empty) begin
            state_reg <= WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
          end
        end
        WR: begin
          if (mem_ack) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end
        end
        RD: begin
          if (mem_ack) begin
            state_reg     <= RD_DONE;
            mem_req       <= 1'b0;
            load_data_reg <= mem_rdata;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Bench for mem_stage_wbuf: directed scenarios then random load/store traffic,
// loads checked against a program-order memory image kept by the bench.
module tb_mem_stage_wbuf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEST_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [DATA_W-1:0] ALU_Res = '0, Val_Rm = '0;
  logic [DEST_W-1:0] Dest = '0;
  logic [31:0]       pc = '0;
  logic              WB_EN_out, MEM_R_EN_out, ready, mem_req, mem_we, mem_ack;
  logic [DATA_W-1:0] ALU_Res_out, DataMemory_out, mem_wdata, mem_rdata;
  logic [DEST_W-1:0] MEM_Dest;
  logic [31:0]       pc_out;
  logic [2:0]        wbuf_count;
  logic [ADDR_W-1:0] mem_addr;

  int ack_lat = 1;
  int req_age = 0;
  int rd_count = 0;
  int rd_wr_before = 0;
  int unstable_cnt = 0;
  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0, wr_checked = 0;

  logic [47:0] wr_log [$];
  logic [47:0] exp_wr [$];
  logic [31:0] bmem      [256];
  logic [31:0] model_mem [256];
  logic        prev_pending = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  mem_stage_wbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .pc(pc),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
    .DataMemory_out(DataMemory_out), .MEM_Dest(MEM_Dest), .pc_out(pc_out),
    .ready(ready), .wbuf_count(wbuf_count), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Backing memory: acks once a request has been visible for ack_lat cycles.
  assign mem_ack   = mem_req && (req_age >= ack_lat - 1);
  assign mem_rdata = bmem[mem_addr[7:0]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_age      <= 0;
      prev_pending <= 1'b0;
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
    end else begin
      if (mem_req && mem_ack) begin
        req_age <= 0;
        if (mem_we) begin
          bmem[mem_addr[7:0]] <= mem_wdata;
          wr_log.push_back({mem_addr, mem_wdata});
        end
      end else if (mem_req) begin
        req_age <= req_age + 1;
      end else begin
        req_age <= 0;
      end
      if (mem_req && !mem_we && req_age == 0) begin
        rd_count     <= rd_count + 1;
        rd_wr_before <= wr_log.size();
      end
      if (prev_pending && (!mem_req || mem_we != prev_we || mem_addr != prev_addr ||
                           (mem_we && mem_wdata != prev_wdata)))
        unstable_cnt <= unstable_cnt + 1;
      prev_pending <= mem_req && !mem_ack;
      prev_we      <= mem_we;
      prev_addr    <= mem_addr;
      prev_wdata   <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction and holds it until the stage reports ready.
  task automatic run_instr(input logic ld, input logic st, input logic [31:0] a,
                           input logic [31:0] d, input logic wb,
                           output int stall, output logic [31:0] dout);
    logic [31:0] p;
    logic [3:0]  dst;
    p   = $urandom;
    dst = 4'($urandom);
    MEM_R_EN = ld; MEM_W_EN = st; ALU_Res = a; Val_Rm = d; pc = p; Dest = dst; WB_EN = wb;
    stall = 0;
    @(negedge clk);
    while (ready !== 1'b1 && stall < 300) begin
      check("wb_gated", WB_EN_out, 0);
      stall++;
      @(negedge clk);
    end
    check("ready_timeout", ready, 1);
    check("wb_out", WB_EN_out, wb);
    check("pc_out", pc_out, p);
    check("dest_out", MEM_Dest, dst);
    check("alu_out", ALU_Res_out, a);
    check("mren_out", MEM_R_EN_out, ld);
    dout = DataMemory_out;
    @(posedge clk); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    int stall;
    logic [31:0] dout;
    run_instr(1'b0, 1'b1, a, d, 1'b0, stall, dout);
    if (exp_stall >= 0) check("store_stall", stall, exp_stall);
    model_mem[int'(a[9:2])] = d;
    exp_wr.push_back({a[17:2], d});
  endtask

  task automatic do_load(input logic [31:0] a, input logic both, input int exp_stall,
                         output logic [31:0] dout);
    int stall;
    run_instr(1'b1, both, a, $urandom, 1'b1, stall, dout);
    if (exp_stall >= 0) check("load_stall", stall, exp_stall);
    check("load_data", dout, model_mem[int'(a[9:2])]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    while ((wbuf_count !== 3'd0 || mem_req !== 1'b0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", n < 500, 1);
  endtask

  task automatic check_writes();
    check("wr_count", wr_log.size(), exp_wr.size());
    for (int i = wr_checked; i < exp_wr.size() && i < wr_log.size(); i++)
      check("wr_order", wr_log[i], exp_wr[i]);
    wr_checked = exp_wr.size();
  endtask

  initial begin
    int          st, base_rd, base_wr;
    logic [31:0] dv, a;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", wbuf_count, 0);
    check("rst_dout", DataMemory_out, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_ready", ready, 1);
    @(posedge clk); #1;

    // Reset mid-WR with three buffered stores; none may reach memory
    ack_lat = 10;
    run_instr(1'b0, 1'b1, 32'h200, 32'h1, 1'b0, st, dv);
    run_instr(1'b0, 1'b1, 32'h204, 32'h2, 1'b0, st, dv);
    run_instr(1'b0, 1'b1, 32'h208, 32'h3, 1'b0, st, dv);
    check("midwr_count", wbuf_count, 3);
    check("midwr_req", mem_req, 1);
    check("midwr_we", mem_we, 1);
    check("midwr_addr", mem_addr, 16'h80);
    check("midwr_wdata", mem_wdata, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_count", wbuf_count, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_count2", wbuf_count, 0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_writes", wr_log.size(), 0);
    check("midrst_req_idle", mem_req, 0);

    // Five back-to-back stores, 3-cycle ack: only the fifth stalls, for one cycle
    ack_lat = 3;
    do_store(32'h000, 32'h1000, 0);
    do_store(32'h004, 32'h1001, 0);
    do_store(32'h008, 32'h1002, 0);
    do_store(32'h00C, 32'h1003, 0);
    do_store(32'h010, 32'h1004, 1);
    drain();
    check_writes();

    // Empty-buffer load, 1-cycle ack: two stall cycles then data
    ack_lat = 1;
    do_store(32'h040, 32'hDEADBEEF, 0);
    drain();
    do_load(32'h040, 1'b0, 2, dv);
    check("load40_data", dv, 32'hDEADBEEF);
    check_writes();

    // Load after two stores: drain-then-read, or forward from the buffer
    ack_lat = 2;
    drain();
    base_rd = rd_count;
    base_wr = wr_log.size();
    do_store(32'h010, 32'h11, 0);
    do_store(32'h014, 32'h22, 0);
`ifdef WBUF_FWD_EN
    do_load(32'h010, 1'b0, 0, dv);
    @(posedge clk); #1;
    check("fwd10_no_read", rd_count, base_rd);
`else
    do_load(32'h010, 1'b0, -1, dv);
    check("ord_read_issued", rd_count, base_rd + 1);
    check("ord_writes_first", rd_wr_before, base_wr + 2);
`endif
    check("ord_data", dv, 32'h11);

    // Two stores to the same word, then load it: youngest data wins
    drain();
    base_rd = rd_count;
    do_store(32'h020, 32'hA, 0);
    do_store(32'h020, 32'hB, 0);
`ifdef WBUF_FWD_EN
    do_load(32'h020, 1'b0, 0, dv);
    @(posedge clk); #1;
    check("fwd20_no_read", rd_count, base_rd);
`else
    do_load(32'h020, 1'b0, -1, dv);
    check("same_read_issued", rd_count, base_rd + 1);
`endif
    check("same_data", dv, 32'hB);
    drain();
    check_writes();

    // Both enables set: behaves as a load, buffer untouched
    ack_lat = 1;
    do_load(32'h040, 1'b1, 2, dv);
    check("both_count", wbuf_count, 0);
    drain();
    check_writes();

    // Random traffic over a small address window
    for (int n = 0; n < 60; n++) begin
      ack_lat = $urandom_range(1, 4);
      a = 32'h100 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 3)) << 20);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_store(a, $urandom, -1);
        4, 5, 6:    do_load(a, 1'b0, -1, dv);
        7:          do_load(a, 1'b1, -1, dv);
        default: begin
          @(posedge clk); #1;
        end
      endcase
    end
    drain();
    check_writes();
    check("req_stable", unstable_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
